// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MDU_DIV0_FLAG_EN adds a div_zero pulse and a short-cut divide-by-zero path.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
`ifdef MDU_DIV0_FLAG_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 div0_q, div0_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     rs_raw_q, rs_raw_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
    logic                 divz_q, divz_d;
`endif

    logic                 is_signed;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       shifted;
    logic                 ge;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     quo, rem;
    logic [2*WIDTH-1:0]   prod;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef MDU_DIV0_FLAG_EN
                    if (op[1] && (rt_data == '0)) begin
                        state_d = StFix;
                    end else begin
                        state_d = StCalc;
                    end
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
        div_zero = divz_q;
`endif
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        rs_raw_d  = rs_raw_q;
        dvsr_d    = dvsr_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        divz_d    = 1'b0;
`endif
        is_signed = ~op[0];
        rs_mag    = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag    = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        shifted   = {rem_q, acc_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, dvsr_q});
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
        quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = neg_rem_q ? -rem_q : rem_q;
        prod      = neg_res_q ? -acc_q : acc_q;

        unique case (state_q)
            StIdle: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    // Both operations start from the magnitude of rs in the low half
                    is_div_d  = op[1];
                    div0_d    = op[1] && (rt_data == '0);
                    neg_res_d = is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    neg_rem_d = is_signed && rs_data[WIDTH-1];
                    rs_raw_d  = rs_data;
                    dvsr_d    = rt_mag;
                    acc_d     = {{WIDTH{1'b0}}, rs_mag};
                    rem_d     = '0;
                    cnt_d     = CntW'(WIDTH);
                end
            end
            StCalc: begin
                cnt_d = cnt_q - CntW'(1);
                if (is_div_q) begin
                    rem_d                = ge ? WIDTH'(shifted - {1'b0, dvsr_q})
                                              : shifted[WIDTH-1:0];
                    acc_d[WIDTH-1:0]     = {acc_q[WIDTH-2:0], ge};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
            end
            StFix: begin
                done_d = 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                divz_d = div0_q;
`endif
                if (is_div_q) begin
                    if (div0_q) begin
                        hi_d = rs_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rs_raw_q  <= '0;
            dvsr_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            divz_q    <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            rs_raw_q  <= rs_raw_d;
            dvsr_q    <= dvsr_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MDU_DIV0_FLAG_EN
            divz_q    <= divz_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; follows MDU_DIV0_FLAG_EN if defined.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic         div_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
`ifdef MDU_DIV0_FLAG_EN
        .div_zero(div_zero),
`endif
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start lands on the next rising edge; returns one cycle after it.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycle k is the cycle following start edge N+k-1; bounded at 100.
    task automatic wait_done(input int cyc0, output int cyc, output int busy_cnt);
        cyc      = cyc0;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el);
        int cyc;
        int bcnt;
        int exp_lat;
        exp_lat = 34;
`ifdef MDU_DIV0_FLAG_EN
        if (o[1] && b == 0) exp_lat = 2;
`endif
        launch(o, a, b);
        wait_done(1, cyc, bcnt);
        check_val({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check_val({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat - 1));
        check_val({tag, " busy at done"}, 64'(busy), 64'd0);
        check_val({tag, " hi"}, 64'(hi), 64'(eh));
        check_val({tag, " lo"}, 64'(lo), 64'(el));
`ifdef MDU_DIV0_FLAG_EN
        check_val({tag, " div_zero"}, 64'(div_zero), 64'(o[1] && b == 0));
`endif
        @(posedge clk);
        #1;
        check_val({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int ndone;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        #12;
        check_val("reset busy", 64'(busy), 64'd0);
        check_val("reset done", 64'(done), 64'd0);
        check_val("reset hi", 64'(hi), 64'd0);
        check_val("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult neg",  2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult nn",   2'b00, 32'hFFFFFFFA, 32'hFFFFFFFC, 32'h00000000, 32'h00000018);
        run_op("mult min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        run_op("div -7/2",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div 7/-2",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("div ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu 5/0",  2'b11, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
        run_op("div -5/0",  2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // Second start mid-calculation must not disturb the first operation
        launch(2'b01, 32'h00010000, 32'h00010000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b11;
        rs_data = 32'd9;
        rt_data = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, cyc, bcnt);
        check_val("ignored start latency", 64'(cyc), 64'd34);
        check_val("ignored start hi", 64'(hi), 64'h1);
        check_val("ignored start lo", 64'(lo), 64'h0);
        count_dones(40, ndone);
        check_val("ignored start single done", 64'(ndone), 64'd0);

        // MT writes while idle
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'h12345678;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check_val("mtlo", 64'(lo), 64'h12345678);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check_val("mthi", 64'(hi), 64'hA5A5A5A5);
        check_val("mthi keeps lo", 64'(lo), 64'h12345678);

        // MTHI while busy is dropped; FIX later overwrites
        launch(2'b01, 32'd2, 32'd3);
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check_val("mthi busy ignored", 64'(hi), 64'hA5A5A5A5);
        wait_done(2, cyc, bcnt);
        check_val("mthi busy latency", 64'(cyc), 64'd34);
        check_val("mthi busy hi", 64'(hi), 64'h0);
        check_val("mthi busy lo", 64'(lo), 64'h6);

        // Asynchronous reset in cycle 10 of an operation
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort busy", 64'(busy), 64'd0);
        check_val("abort hi", 64'(hi), 64'd0);
        check_val("abort lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_dones(40, ndone);
        check_val("abort no done", 64'(ndone), 64'd0);
        check_val("abort hi held", 64'(hi), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
